// File: rtl/random_move_engine.sv
// rtl/random_move_engine.sv - opponent-move picker: LFSR start cell + linear probe for an empty cell
//
// Purpose: on a timeout request, snapshot the board and draw a pseudo-random
//   start cell from a free-running LFSR. Probe forward with wrap-around for the
//   first empty cell. Return that cell with a one-cycle valid pulse, or pulse
//   no_move if the snapshot is full.
// Ports:
//   clk      - system clock, rising edge
//   Reset    - asynchronous active-high reset
//   timeout  - move request (level, sampled only while idle)
//   Cells    - board, cell i = Cells[i*CELL_BITS +: CELL_BITS], all-zero = empty
//   move     - chosen cell index, held until the next valid
//   valid    - one-cycle pulse, move is new and points to an empty cell
//   no_move  - one-cycle pulse, snapshot had no empty cell
//   busy     - high while probing
module random_move_engine #(
  parameter int          NUM_CELLS = 9,
  parameter int          CELL_BITS = 2,
  parameter int          LFSR_W    = 16,
  parameter logic [15:0] SEED      = 16'hACE1,
  localparam int         IDX_W     = $clog2(NUM_CELLS)
) (
  input  logic                           clk,
  input  logic                           Reset,
  input  logic                           timeout,
  input  logic [NUM_CELLS*CELL_BITS-1:0] Cells,
  output logic [IDX_W-1:0]               move,
  output logic                           valid,
  output logic                           no_move,
  output logic                           busy
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_PROBE = 1'b1
  } state_t;

  state_t                         state_q, state_d;
  logic [LFSR_W-1:0]              lfsr_q, lfsr_d;
  logic [NUM_CELLS*CELL_BITS-1:0] snap_q, snap_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [IDX_W-1:0]               cnt_q, cnt_d;
  logic [IDX_W-1:0]               move_q, move_d;
  logic                           valid_q, valid_d;
  logic                           no_move_q, no_move_d;

  logic [LFSR_W-1:0]              start_full;
  logic [IDX_W-1:0]               start_idx;
  logic                           cell_empty;

  // Fibonacci LFSR, x^16+x^14+x^13+x^11+1; runs every cycle regardless of state.
  assign lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // Modulo is taken on the full LFSR word; the result always fits in IDX_W.
  assign start_full = lfsr_q % LFSR_W'(NUM_CELLS);
  assign start_idx  = start_full[IDX_W-1:0];

  // Decode the snapshot cell under the probe pointer with constant slices only.
  always_comb begin
    cell_empty = 1'b0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cell_empty = (snap_q[i*CELL_BITS +: CELL_BITS] == '0);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    move_d    = move_q;
    valid_d   = 1'b0;
    no_move_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (timeout) begin
          snap_d  = Cells;
          idx_d   = start_idx;
          cnt_d   = '0;
          state_d = S_PROBE;
        end
      end

      S_PROBE: begin
        if (cell_empty) begin
          move_d  = idx_q;
          valid_d = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q == IDX_W'(NUM_CELLS - 1)) begin
          // Every cell has been visited once: the snapshot is full.
          no_move_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          idx_d = (idx_q == IDX_W'(NUM_CELLS - 1)) ? '0 : idx_q + 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= S_IDLE;
      lfsr_q    <= SEED;
      snap_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      move_q    <= '0;
      valid_q   <= 1'b0;
      no_move_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      snap_q    <= snap_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      move_q    <= move_d;
      valid_q   <= valid_d;
      no_move_q <= no_move_d;
    end
  end

  assign move    = move_q;
  assign valid   = valid_q;
  assign no_move = no_move_q;
  assign busy    = (state_q == S_PROBE);

endmodule

// File: tb/tb_random_move_engine.sv
// tb/tb_random_move_engine.sv - self-checking bench for random_move_engine
module tb_random_move_engine;

  localparam int          N    = 9;
  localparam int          CB   = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        Reset;
  logic        timeout;
  logic [17:0] Cells;
  logic [3:0]  move;
  logic        valid;
  logic        no_move;
  logic        busy;

  always #5 clk = ~clk;

  random_move_engine #(
    .NUM_CELLS(N),
    .CELL_BITS(CB),
    .LFSR_W   (16),
    .SEED     (SEED)
  ) dut (
    .clk    (clk),
    .Reset  (Reset),
    .timeout(timeout),
    .Cells  (Cells),
    .move   (move),
    .valid  (valid),
    .no_move(no_move),
    .busy   (busy)
  );

  // Reference LFSR, stepped on the same edges as the design's.
  logic [15:0] lfsr_m;
  always @(posedge clk or posedge Reset) begin
    if (Reset) lfsr_m <= SEED;
    else       lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  int n_cmp = 0;
  int n_bad = 0;
  int exp_move_q[$];
  int exp_kind_q[$];
  int exp_lat_q[$];
  int last_move = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called right after a negedge. Raises timeout so the next posedge is edge T,
  // predicts the result from the current board and model LFSR, then waits.
  task automatic request(input string tag, input bit hold, input bit swap,
                         input logic [17:0] new_cells);
    int  start;
    int  c;
    int  fm;
    int  k;
    int  cnt;
    bit  found;
    bit  done;
    bit  busy_ok;
    int  obs_kind;
    int  obs_move;
    timeout = 1'b1;
    start   = int'(lfsr_m % 16'd9);
    found   = 1'b0;
    fm      = 0;
    k       = 0;
    for (int j = 0; j < N; j++) begin
      if (!found) begin
        c = (start + j) % N;
        if (Cells[c*CB +: CB] == 2'b00) begin
          found = 1'b1;
          fm    = c;
          k     = j;
        end
      end
    end
    if (found) begin
      exp_move_q.push_back(fm);
      exp_kind_q.push_back(2);
      exp_lat_q.push_back(k + 2);
      last_move = fm;
    end else begin
      exp_move_q.push_back(last_move);
      exp_kind_q.push_back(1);
      exp_lat_q.push_back(N + 1);
    end

    cnt      = 0;
    done     = 1'b0;
    busy_ok  = 1'b1;
    obs_kind = 0;
    obs_move = 0;
    while (!done && cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (valid || no_move) begin
        done     = 1'b1;
        obs_kind = {30'd0, valid, no_move};
        obs_move = int'(move);
      end else if (busy !== 1'b1) begin
        busy_ok = 1'b0;
      end
      if (cnt == 1 && !hold) timeout = 1'b0;
      if (cnt == 1 && swap)  Cells = new_cells;
    end

    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_kind"}, 32'(obs_kind), 32'(exp_kind_q.pop_front()));
    chk({tag, "_move"}, 32'(obs_move), 32'(exp_move_q.pop_front()));
    chk({tag, "_lat"},  32'(cnt), 32'(exp_lat_q.pop_front()));
    chk({tag, "_busy"}, 32'(busy_ok), 32'd1);

    if (!hold) begin
      @(negedge clk);
      chk({tag, "_pulse_end"}, {30'd0, valid, no_move}, 32'd0);
      chk({tag, "_idle"}, 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int guard;
    Reset   = 1'b1;
    timeout = 1'b0;
    Cells   = '0;
    repeat (3) @(negedge clk);
    Reset = 1'b0;

    // Reset state and LFSR sequence over idle cycles.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_lfsr", 32'(dut.lfsr_q), 32'(lfsr_m));
      chk("rst_outs", {27'd0, move, valid, no_move, busy}, 32'd0);
    end

    // Only cell 4 empty.
    Cells = 18'h3FCFF;
    request("one_empty", 1'b0, 1'b0, 18'h0);

    // Full board: no_move, move keeps previous value.
    Cells = 18'h3FFFF;
    request("full", 1'b0, 1'b0, 18'h0);

    // Empty board: move is the LFSR-derived start cell.
    Cells = 18'h00000;
    request("empty", 1'b0, 1'b0, 18'h0);

    // Start at index 8 with cells 8 and 0 occupied, cell 1 empty.
    Cells = 18'h3FFF3;
    guard = 0;
    while (int'(lfsr_m % 16'd9) != 8 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("wrap_start_found", 32'(lfsr_m % 16'd9), 32'd8);
    request("wrap", 1'b0, 1'b0, 18'h0);

    // Board cleared during the probe: the snapshot decides.
    Cells = 18'h3FCFF;
    request("snap", 1'b0, 1'b1, 18'h00000);

    // timeout held high: one result per IDLE entry.
    Cells = 18'h00000;
    request("hold0", 1'b1, 1'b0, 18'h0);
    request("hold1", 1'b1, 1'b0, 18'h0);
    request("hold2", 1'b0, 1'b0, 18'h0);

    // Asynchronous reset in the middle of a full-board probe.
    Cells   = 18'h3FFFF;
    timeout = 1'b1;
    @(negedge clk);
    timeout = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    #2 Reset = 1'b1;
    #1;
    chk("mid_rst_outs", {27'd0, move, valid, no_move, busy}, 32'd0);
    chk("mid_rst_lfsr", 32'(dut.lfsr_q), 32'(SEED));
    @(negedge clk);
    Reset     = 1'b0;
    last_move = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", {29'd0, valid, no_move, busy}, 32'd0);
    end
    chk("post_rst_lfsr", 32'(dut.lfsr_q), 32'(lfsr_m));

    // Normal operation after reset.
    Cells = 18'h0FFFF;
    request("post_rst", 1'b0, 1'b0, 18'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
